// File: rtl/leaf_out_packetizer.sv
// leaf_out_packetizer: round-robin serializer of user output streams into 49-bit BFT packets.
// Optional credit flow control is enabled by defining LEAF_OUT_CREDIT_EN.
module leaf_out_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 3,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [PACKET_BITS-1:0]                din_leaf_bft2interface,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
  input  logic                                  resend,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user
);
  localparam int ADDR_LSB = PAYLOAD_BITS;
  localparam int PORT_LSB = ADDR_LSB + NUM_ADDR_BITS;
  localparam int LEAF_LSB = PORT_LSB + NUM_PORT_BITS;
  localparam int IDX_BITS = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam logic [3:0] NUM_K = 4'(NUM_OUT_PORTS);

  logic                     w_in_vld;
  logic [NUM_PORT_BITS-1:0] w_in_port;
  logic [3:0]               w_cfg_k;
  logic                     w_cfg_hit;
  logic                     w_unused;

  assign w_in_vld  = din_leaf_bft2interface[PACKET_BITS-1];
  assign w_in_port = din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS];
  assign w_cfg_k   = din_leaf_bft2interface[23:20];
  assign w_cfg_hit = w_in_vld && (w_in_port == '0) && (w_cfg_k != 4'd0) && (w_cfg_k <= NUM_K);
  assign w_unused  = ^{din_leaf_bft2interface[LEAF_LSB +: NUM_LEAF_BITS],
                       din_leaf_bft2interface[ADDR_LSB +: NUM_ADDR_BITS],
                       din_leaf_bft2interface[PAYLOAD_BITS-1:24],
                       din_leaf_bft2interface[10:0]};

`ifdef LEAF_OUT_CREDIT_EN
  logic [3:0] w_fs_k;
  logic       w_fs_hit;
  assign w_fs_k   = din_leaf_bft2interface[3:0];
  assign w_fs_hit = w_in_vld && (w_in_port == NUM_PORT_BITS'(1)) && (w_fs_k != 4'd0) && (w_fs_k <= NUM_K);
`endif

  logic [NUM_OUT_PORTS-1:0] w_cfgd;
  logic [NUM_OUT_PORTS-1:0] w_has_credit;
  logic [NUM_OUT_PORTS-1:0] w_elig;
  logic [NUM_OUT_PORTS-1:0] w_grant;
  logic [NUM_LEAF_BITS-1:0] w_dst_leaf     [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] w_dst_port     [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] w_seq          [NUM_OUT_PORTS];
  logic [PAYLOAD_BITS-1:0]  w_user_payload [NUM_OUT_PORTS];
  logic                     w_grant_any;
  logic [IDX_BITS-1:0]      w_grant_idx;
  logic                     w_out_free;
  logic [IDX_BITS-1:0]      r_rr_ptr;
  logic [PACKET_BITS-1:0]   r_out_pkt;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_out
      localparam logic [3:0] K = 4'(gi + 1);
      logic                     r_cfgd;
      logic [NUM_LEAF_BITS-1:0] r_dst_leaf;
      logic [NUM_PORT_BITS-1:0] r_dst_port;
      logic [NUM_ADDR_BITS-1:0] r_seq;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_cfgd     <= 1'b0;
          r_dst_leaf <= '0;
          r_dst_port <= '0;
          r_seq      <= '0;
        end else begin
          if (w_cfg_hit && (w_cfg_k == K)) begin
            r_cfgd     <= 1'b1;
            r_dst_leaf <= NUM_LEAF_BITS'(din_leaf_bft2interface[19:15]);
            r_dst_port <= NUM_PORT_BITS'(din_leaf_bft2interface[14:11]);
          end
          if (w_grant[gi]) r_seq <= r_seq + NUM_ADDR_BITS'(1);
        end
      end

      assign w_cfgd[gi]         = r_cfgd;
      assign w_dst_leaf[gi]     = r_dst_leaf;
      assign w_dst_port[gi]     = r_dst_port;
      assign w_seq[gi]          = r_seq;
      assign w_user_payload[gi] = din_leaf_user2interface[gi*PAYLOAD_BITS +: PAYLOAD_BITS];

`ifdef LEAF_OUT_CREDIT_EN
      localparam logic [NUM_BRAM_ADDR_BITS:0] CREDIT_MAX = {1'b1, {NUM_BRAM_ADDR_BITS{1'b0}}};
      logic [NUM_BRAM_ADDR_BITS:0] r_credit;
      logic [31:0]                 w_credit_sum;

      // Send and update on the same cycle combine before saturating; a send never sees zero credit.
      assign w_credit_sum = 32'(r_credit) - 32'(w_grant[gi]) +
                            ((w_fs_hit && (w_fs_k == K)) ? 32'(FREESPACE_UPDATE_SIZE) : 32'd0);

      always_ff @(posedge clk) begin
        if (reset) r_credit <= CREDIT_MAX;
        else       r_credit <= (w_credit_sum > 32'(CREDIT_MAX)) ? CREDIT_MAX
                                                                 : w_credit_sum[NUM_BRAM_ADDR_BITS:0];
      end
      assign w_has_credit[gi] = (r_credit != '0);
`else
      assign w_has_credit[gi] = 1'b1;
`endif
    end
  endgenerate

  assign w_out_free = !r_out_pkt[PACKET_BITS-1] || !resend;
  assign w_elig     = vld_user2interface & w_cfgd & w_has_credit &
                      {NUM_OUT_PORTS{!resend && !reset && w_out_free}};

  // Round-robin: first eligible at or above the pointer, else first eligible from the bottom.
  always_comb begin
    w_grant     = '0;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (!w_grant_any && w_elig[i] && (IDX_BITS'(i) >= r_rr_ptr)) begin
        w_grant_any = 1'b1;
        w_grant_idx = IDX_BITS'(i);
        w_grant[i]  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (!w_grant_any && w_elig[i]) begin
        w_grant_any = 1'b1;
        w_grant_idx = IDX_BITS'(i);
        w_grant[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_pkt <= '0;
      r_rr_ptr  <= '0;
    end else if (w_grant_any) begin
      r_out_pkt <= {1'b1, w_dst_leaf[w_grant_idx], w_dst_port[w_grant_idx],
                    w_seq[w_grant_idx], w_user_payload[w_grant_idx]};
      r_rr_ptr  <= (w_grant_idx == IDX_BITS'(NUM_OUT_PORTS - 1)) ? '0 : w_grant_idx + IDX_BITS'(1);
    end else if (!resend) begin
      r_out_pkt <= '0;
    end
  end

  assign dout_leaf_interface2bft = resend ? '0 : r_out_pkt;
  assign ack_interface2user      = w_grant;
endmodule

// File: tb/tb_leaf_out_packetizer.sv
// Scoreboard bench for leaf_out_packetizer: directed vectors, queue of expected packets checked by a monitor.
`timescale 1ns/1ps
module tb_leaf_out_packetizer;
  localparam int N = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [48:0]      din_bft;
  logic [48:0]      dout;
  logic             resend;
  logic [N*32-1:0]  din_user;
  logic [N-1:0]     vld;
  logic [N-1:0]     ack;

  leaf_out_packetizer dut (
    .clk                     (clk),
    .reset                   (reset),
    .din_leaf_bft2interface  (din_bft),
    .dout_leaf_interface2bft (dout),
    .resend                  (resend),
    .din_leaf_user2interface (din_user),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [48:0] pkt;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          tb_delay = 0;
  bit          mon_en = 1'b0;
  logic [31:0] pay    [N];
  logic [4:0]  m_leaf [N];
  logic [3:0]  m_port [N];
  logic [6:0]  m_seq  [N];
  logic [48:0] last_dout;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    din_user = '0;
    for (int k = 0; k < N; k++) din_user[k*32 +: 32] = pay[k];
  end

  function automatic logic [48:0] cfg_pkt(input int k, input int leaf, input int port);
    return {1'b1, 5'd0, 4'd0, 7'd0, 8'd0, 4'(k), 5'(leaf), 4'(port), 11'd0};
  endfunction

  function automatic logic [48:0] fs_pkt(input int k);
    return {1'b1, 5'd0, 4'd1, 7'd0, 28'd0, 4'(k)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_leaf[k] = '0;
      m_port[k] = '0;
      m_seq[k]  = '0;
    end
  endtask

  task automatic chk(input string name, input logic [48:0] got, input logic [48:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check ack mid-cycle, queue the packets the acks imply.
  task automatic step(input logic [48:0] bft, input logic [N-1:0] v,
                      input logic [N-1:0] exp_ack, input bit rs);
    exp_t e;
    din_bft = bft;
    vld     = v;
    resend  = rs;
    @(negedge clk);
    last_dout = dout;
    checks++;
    if (ack !== exp_ack) begin
      errors++;
      $display("FAIL ack cyc=%0d got=%b exp=%b", cyc, ack, exp_ack);
    end
    for (int k = 0; k < N; k++) begin
      if (exp_ack[k]) begin
        e.pkt = {1'b1, m_leaf[k], m_port[k], m_seq[k], pay[k]};
        e.cyc = cyc + 1 + tb_delay;
        exp_q.push_back(e);
        m_seq[k] = m_seq[k] + 7'd1;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (exp_ack[k]) pay[k] = pay[k] + 32'h01010101;
    din_bft = '0;
  endtask

  task automatic do_cfg(input int k, input int leaf, input int port,
                        input logic [N-1:0] v, input logic [N-1:0] exp_ack);
    step(cfg_pkt(k, leaf, port), v, exp_ack, 1'b0);
    m_leaf[k-1] = 5'(leaf);
    m_port[k-1] = 4'(port);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        checks++;
        if (dout[48] === 1'b1) begin
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pkt_unexpected cyc=%0d got=%h exp=none", cyc, dout);
          end else begin
            e = exp_q.pop_front();
            if (dout !== e.pkt || cyc != e.cyc) begin
              errors++;
              $display("FAIL pkt got=%h@%0d exp=%h@%0d", dout, cyc, e.pkt, e.cyc);
            end else begin
              $display("pkt cyc=%0d dout=%h ok", cyc, dout);
            end
          end
        end else if (dout !== '0) begin
          errors++;
          $display("FAIL idle_dout cyc=%0d got=%h exp=0", cyc, dout);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    din_bft = '0;
    vld     = '0;
    resend  = 1'b0;
    for (int k = 0; k < N; k++) pay[k] = 32'(k + 1) << 28;
    model_reset();
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step('0, 3'b000, 3'b000, 1'b0);
    step('0, 3'b000, 3'b000, 1'b0);
    chk("reset_dout", last_dout, '0);
    reset = 1'b0;

    // Basic send: output 1 -> leaf 5 port 3
    do_cfg(1, 5, 3, 3'b000, 3'b000);
    pay[0] = 32'hDEADBEEF;
    step('0, 3'b001, 3'b001, 1'b0);
    step('0, 3'b001, 3'b001, 1'b0);
    chk("first_word", last_dout, 49'h12980DEADBEEF);
    step('0, 3'b000, 3'b000, 1'b0);
    chk("second_word", last_dout, 49'h12981DFAEBFF0);
    step('0, 3'b000, 3'b000, 1'b0);
    chk("idle_after", last_dout, '0);

    // Unconfigured output 2; invalid-flag config is ignored; config takes effect next cycle
    repeat (3) step('0, 3'b010, 3'b000, 1'b0);
    chk("unconfigured_dout", last_dout, '0);
    step(cfg_pkt(2, 7, 9) & {1'b0, {48{1'b1}}}, 3'b010, 3'b000, 1'b0);
    step(cfg_pkt(0, 7, 9), 3'b010, 3'b000, 1'b0);
    do_cfg(2, 7, 9, 3'b010, 3'b000);
    step('0, 3'b010, 3'b010, 1'b0);
    step('0, 3'b000, 3'b000, 1'b0);

    // Round robin across all three outputs
    reset = 1'b1;
    step('0, 3'b000, 3'b000, 1'b0);
    reset = 1'b0;
    model_reset();
    do_cfg(1, 1, 1, 3'b000, 3'b000);
    do_cfg(2, 2, 2, 3'b000, 3'b000);
    do_cfg(3, 3, 3, 3'b000, 3'b000);
    for (int i = 0; i < 6; i++) step('0, 3'b111, 3'b001 << (i % 3), 1'b0);

    // resend holds the pending packet for 3 cycles
    tb_delay = 3;
    step('0, 3'b001, 3'b001, 1'b0);
    tb_delay = 0;
    for (int i = 0; i < 3; i++) begin
      step('0, 3'b001, 3'b000, 1'b1);
      chk("resend_dout", last_dout, '0);
    end
    step('0, 3'b001, 3'b001, 1'b0);
    step('0, 3'b000, 3'b000, 1'b0);

    // Sequence wrap and credit exhaustion
    reset = 1'b1;
    step('0, 3'b000, 3'b000, 1'b0);
    reset = 1'b0;
    model_reset();
`ifdef LEAF_OUT_CREDIT_EN
    step(fs_pkt(1), 3'b000, 3'b000, 1'b0);
`endif
    do_cfg(1, 2, 4, 3'b000, 3'b000);
    repeat (128) step('0, 3'b001, 3'b001, 1'b0);
`ifdef LEAF_OUT_CREDIT_EN
    repeat (2) step('0, 3'b001, 3'b000, 1'b0);
    step(fs_pkt(1), 3'b001, 3'b000, 1'b0);
    repeat (64) step('0, 3'b001, 3'b001, 1'b0);
    step('0, 3'b001, 3'b000, 1'b0);
    step(fs_pkt(1), 3'b001, 3'b000, 1'b0);
`else
    repeat (2) step('0, 3'b001, 3'b001, 1'b0);
`endif

    // Reset mid-stream: output drops, state unconfigured, seq restarts
    step('0, 3'b001, 3'b001, 1'b0);
    reset = 1'b1;
    step('0, 3'b001, 3'b000, 1'b0);
    reset = 1'b0;
    model_reset();
    step('0, 3'b001, 3'b000, 1'b0);
    chk("reset_flush", last_dout, '0);
    do_cfg(1, 6, 1, 3'b001, 3'b000);
    step('0, 3'b001, 3'b001, 1'b0);
    step('0, 3'b000, 3'b000, 1'b0);
    step('0, 3'b000, 3'b000, 1'b0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
